// File: rtl/reset_seq.sv
// Reset sequencer: holds three reset domains after chip or soft reset and
// releases them in order periph -> bus -> cpu with programmable spacing.
module reset_seq #(
   parameter int STRETCH   = 16,
   parameter int STAGE_GAP = 8,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       soft_req,
   input  logic       cpu_hold,
   input  logic       cause_clr,
   output logic       periph_reset,
   output logic       bus_reset,
   output logic       cpu_reset,
   output logic       seq_done,
   output logic [1:0] reset_cause
);

   // state     | meaning
   // HOLD      | all domains in reset, counting the reset stretch
   // PERIPH_UP | peripherals released, counting gap before bus release
   // BUS_UP    | bus released, counting gap (then cpu_hold) before cpu release
   // RUN       | all domains out of reset
   typedef enum logic [1:0] {HOLD, PERIPH_UP, BUS_UP, RUN} state_t;

   localparam logic [CNT_W-1:0] STRETCH_TC = CNT_W'(STRETCH - 1);
   localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(STAGE_GAP - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             periph_q, periph_d;
   logic             bus_q, bus_d;
   logic             cpu_q, cpu_d;
   logic             done_q, done_d;
   logic [1:0]       cause_q, cause_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      periph_d = periph_q;
      bus_d    = bus_q;
      cpu_d    = cpu_q;
      done_d   = done_q;
      cause_d  = cause_q;
      if (soft_req) begin
         state_d  = HOLD;
         cnt_d    = '0;
         periph_d = 1'b1;
         bus_d    = 1'b1;
         cpu_d    = 1'b1;
         done_d   = 1'b0;
         cause_d  = 2'b10;
      end else begin
         if (cause_clr) cause_d = 2'b00;
         unique case (state_q)
            HOLD: begin
               if (cnt_q == STRETCH_TC) begin
                  state_d  = PERIPH_UP;
                  cnt_d    = '0;
                  periph_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PERIPH_UP: begin
               if (cnt_q == GAP_TC) begin
                  state_d = BUS_UP;
                  cnt_d   = '0;
                  bus_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            BUS_UP: begin
               // counter parks at terminal count while cpu_hold keeps the CPU down
               if (cnt_q == GAP_TC) begin
                  if (!cpu_hold) begin
                     state_d = RUN;
                     cnt_d   = '0;
                     cpu_d   = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
            end
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= HOLD;
         cnt_q    <= '0;
         periph_q <= 1'b1;
         bus_q    <= 1'b1;
         cpu_q    <= 1'b1;
         done_q   <= 1'b0;
         cause_q  <= 2'b01;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         periph_q <= periph_d;
         bus_q    <= bus_d;
         cpu_q    <= cpu_d;
         done_q   <= done_d;
         cause_q  <= cause_d;
      end
   end

   assign periph_reset = periph_q;
   assign bus_reset    = bus_q;
   assign cpu_reset    = cpu_q;
   assign seq_done     = done_q;
   assign reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: default and minimum-parameter instances share stimulus
// and are checked every cycle against an edge-count release model.
module tb_reset_seq;

   localparam int S0 = 16, G0 = 8;
   localparam int S1 = 1,  G1 = 1;

   logic clk = 1'b0;
   logic reset = 1'b1, soft_req = 1'b0, cpu_hold = 1'b0, cause_clr = 1'b0;
   logic p0, b0, c0, d0, p1, b1, c1, d1;
   logic [1:0] rc0, rc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reset_seq #(.STRETCH(S0), .STAGE_GAP(G0), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .soft_req(soft_req), .cpu_hold(cpu_hold),
      .cause_clr(cause_clr), .periph_reset(p0), .bus_reset(b0),
      .cpu_reset(c0), .seq_done(d0), .reset_cause(rc0));

   reset_seq #(.STRETCH(S1), .STAGE_GAP(G1), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .soft_req(soft_req), .cpu_hold(cpu_hold),
      .cause_clr(cause_clr), .periph_reset(p1), .bus_reset(b1),
      .cpu_reset(c1), .seq_done(d1), .reset_cause(rc1));

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: k = edges since last reset/soft_req; each domain releases once k
   // reaches its cumulative threshold, CPU additionally needs cpu_hold=0.
   int  mk[2];
   bit  mrel[2];
   logic [1:0] mcause[2];
   bit  started = 0;
   int  ms[2] = '{S0, S1};
   int  mg[2] = '{G0, G1};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mk[i] = 0; mrel[i] = 0; mcause[i] = 2'b01;
         end else if (soft_req) begin
            mk[i] = 0; mrel[i] = 0; mcause[i] = 2'b10;
         end else begin
            if (cause_clr) mcause[i] = 2'b00;
            mk[i] = mk[i] + 1;
            if (mk[i] >= ms[i] + 2 * mg[i] && !cpu_hold) mrel[i] = 1;
         end
      end
      if (reset) started = 1;
   end

   function automatic logic [7:0] model_vec(input int i);
      logic ep, eb;
      ep = (mk[i] < ms[i]);
      eb = (mk[i] < ms[i] + mg[i]);
      return {2'b00, ep, eb, ~mrel[i], mrel[i], mcause[i]};
   endfunction

   always @(negedge clk) begin
      if (started) begin
         chk("u0_cycle", {2'b00, p0, b0, c0, d0, rc0}, model_vec(0));
         chk("u1_cycle", {2'b00, p1, b1, c1, d1, rc1}, model_vec(1));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // power-up
      step(5);
      chk("reset_state", {2'b00, p0, b0, c0, d0, rc0}, 8'b0011_1001);
      reset = 1'b0;
      for (int e = 1; e <= 34; e++) begin
         step(1);
         case (e)
            1:  chk("min_periph_e1", {6'd0, p1, b1}, 8'b01);
            2:  chk("min_bus_e2", {6'd0, b1, c1}, 8'b01);
            3:  chk("min_cpu_e3", {6'd0, c1, d1}, 8'b01);
            15: chk("periph_e15", {7'd0, p0}, 8'd1);
            16: chk("periph_e16", {6'd0, p0, b0}, 8'b01);
            23: chk("bus_e23", {7'd0, b0}, 8'd1);
            24: chk("bus_e24", {6'd0, b0, c0}, 8'b01);
            31: chk("cpu_e31", {6'd0, c0, d0}, 8'b10);
            32: chk("cpu_e32", {4'd0, c0, d0, rc0}, 8'b0101);
            default: ;
         endcase
      end

      // debug hold
      reset = 1'b1; cpu_hold = 1'b1;
      step(2);
      reset = 1'b0;
      for (int e = 1; e <= 41; e++) begin
         step(1);
         case (e)
            24: chk("hold_bus_e24", {7'd0, b0}, 8'd0);
            39: begin
               chk("hold_cpu_e39", {6'd0, c0, c1}, 8'b11);
               cpu_hold = 1'b0;
            end
            40: chk("hold_cpu_e40", {4'd0, c0, d0, c1, d1}, 8'b0101);
            default: ;
         endcase
      end

      // soft reset pulse in RUN
      soft_req = 1'b1;
      step(1);
      chk("soft_assert", {2'b00, p0, b0, c0, d0, rc0}, 8'b0011_1010);
      soft_req = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         step(1);
         case (e)
            15: chk("soft_periph_15", {7'd0, p0}, 8'd1);
            16: chk("soft_periph_16", {7'd0, p0}, 8'd0);
            24: chk("soft_bus_24", {7'd0, b0}, 8'd0);
            32: chk("soft_cpu_32", {4'd0, c0, d0, rc0}, 8'b0110);
            default: ;
         endcase
      end

      // abort mid-sequence with chip reset
      soft_req = 1'b1;
      step(1);
      soft_req = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step(1);
         if (e == 19) begin
            chk("abort_pre", {6'd0, p0, b0}, 8'b01);
            reset = 1'b1;
         end
      end
      chk("abort_assert", {2'b00, p0, b0, c0, d0, rc0}, 8'b0011_1001);
      step(1);
      reset = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         step(1);
         case (e)
            16: chk("abort_periph_16", {6'd0, p0, b0}, 8'b01);
            24: chk("abort_bus_24", {6'd0, b0, c0}, 8'b01);
            32: chk("abort_cpu_32", {4'd0, c0, d0, rc0}, 8'b0101);
            default: ;
         endcase
      end

      // priority: soft_req beats cause_clr, then cause_clr alone
      soft_req = 1'b1; cause_clr = 1'b1;
      step(1);
      chk("prio_cause", {6'd0, rc0}, 8'b10);
      soft_req = 1'b0; cause_clr = 1'b0;
      step(33);
      cause_clr = 1'b1;
      step(1);
      cause_clr = 1'b0;
      chk("clr_cause", {2'b00, p0, b0, c0, d0, rc0}, 8'b0000_0100);
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reset_seq.md
# reset_seq

Reset sequencer sitting directly downstream of the clock generator. It takes the chip-level reset and releases three reset domains in a fixed order, with programmable spacing: peripherals first, then the bus, then the CPU. It also accepts a soft-reset request that re-runs the full sequence, and records the reset cause for software. All outputs are registered, so the domains see glitch-free, clock-aligned reset edges.

## Interface
Parameters:
- STRETCH, 16: cycles of `reset` low required before `periph_reset` releases; legal range 1 to 2^CNT_W-1.
- STAGE_GAP, 8: cycles between successive domain releases; legal range 1 to 2^CNT_W-1.
- CNT_W, 8: width of the shared stage counter.

Ports:
- clk, in, 1: system clock. Every register updates on the rising edge.
- reset, in, 1: synchronous, active-high reset, driven by the chip reset. One clock; reset is synchronous and active-high.
- soft_req, in, 1: soft-reset request, level-sensitive and active-high.
- cpu_hold, in, 1: while high, keeps the CPU in reset after the bus has been released (loader/debug use).
- cause_clr, in, 1: clears `reset_cause` to 00.
- periph_reset, out, 1: active-high peripheral-domain reset.
- bus_reset, out, 1: active-high bus-domain reset.
- cpu_reset, out, 1: active-high CPU-domain reset.
- seq_done, out, 1: high once all three domains are out of reset.
- reset_cause, out, 2: cause of the last reset. 01 = chip reset, 10 = soft reset, 00 = cleared.

## Operation
- States: HOLD, PERIPH_UP, BUS_UP, RUN. A single counter `cnt` is shared by all states.
- Priority, highest first: `reset`, then `soft_req`, then `cause_clr`, then normal sequencing.
- `reset`=1 (any state):
  - state=HOLD, cnt=0.
  - periph_reset=bus_reset=cpu_reset=1, seq_done=0.
  - reset_cause=01.
- `soft_req`=1 with reset=0 (any state, HOLD included):
  - state=HOLD, cnt=0.
  - All three domain resets asserted, seq_done=0.
  - reset_cause=10.
  - If soft_req is held high, the sequence stays in HOLD, exactly as if reset were held.
- HOLD:
  - If cnt==STRETCH-1: go to PERIPH_UP, cnt=0, periph_reset<=0.
  - Otherwise cnt++.
- PERIPH_UP:
  - If cnt==STAGE_GAP-1: go to BUS_UP, cnt=0, bus_reset<=0.
  - Otherwise cnt++.
- BUS_UP:
  - If cnt==STAGE_GAP-1 and cpu_hold=0: go to RUN, cpu_reset<=0, seq_done<=1.
  - If cnt==STAGE_GAP-1 and cpu_hold=1: stay in BUS_UP with cnt frozen at STAGE_GAP-1. Release happens on the first edge that samples cpu_hold=0.
  - Otherwise cnt++; cpu_hold is ignored until the gap has expired.
- RUN: all domain resets stay 0 and seq_done stays 1. cpu_hold has no effect.
- cause_clr=1 with no reset or soft_req: reset_cause<=00, in any state.
- Invariant: a domain never releases before the domain that precedes it in the order (periph, then bus, then cpu). seq_done=1 exactly when cpu_reset=0.

## Timing
- Reset values:
  - periph_reset=1, bus_reset=1, cpu_reset=1.
  - seq_done=0.
  - reset_cause=01.
  - Internal state: HOLD, cnt=0.
- Edge numbering: edge k is the k-th rising edge that samples reset=0 and soft_req=0, counted from the end of reset.
- Release edges with cpu_hold=0:
  - periph_reset falls after edge STRETCH.
  - bus_reset falls after edge STRETCH+STAGE_GAP.
  - cpu_reset and seq_done change after edge STRETCH+2*STAGE_GAP.
  - With defaults: edges 16, 24 and 32.
- Soft reset: the edge that samples soft_req=1 asserts all domain resets, so they read 1 in the following cycle. The release schedule then restarts from edge numbering 0.
- Reset or soft_req mid-sequence aborts immediately. No partial stage is kept.
- cnt never exceeds max(STRETCH, STAGE_GAP)-1. Nothing wraps.

## Test plan
- Power-up with defaults: hold reset for 5 cycles, then drop it, with cpu_hold=0 → periph_reset low after edge 16, bus_reset after edge 24, cpu_reset and seq_done after edge 32; reset_cause=01 throughout.
- Debug hold: cpu_hold=1 from reset, released at edge 40 → cpu_reset stays 1 through edge 39 and falls after edge 40 (the first edge sampling cpu_hold=0); bus_reset still falls after edge 24.
- Soft reset in RUN: a 1-cycle soft_req pulse → all domain resets read 1 in the next cycle, seq_done=0, reset_cause=10; the release sequence repeats at +16, +24 and +32 edges after the pulse.
- Abort mid-sequence: assert reset at edge 20 (periph already released) → all domain resets read 1 in the next cycle; after reset drops, the full 16/24/32 schedule restarts and reset_cause=01.
- Priority: apply soft_req and cause_clr together in RUN → reset_cause=10. Then cause_clr alone → reset_cause=00, with the domain resets unaffected.
- Minimum parameters, STRETCH=1 and STAGE_GAP=1 → periph_reset falls after edge 1, bus_reset after edge 2, cpu_reset after edge 3.
